// File: rtl/and2_word.sv
// ----------------------------------------------------------------------------
// and2_word
// ----------------------------------------------------------------------------
// Bitwise two-input AND primitive for the ALU/logic-unit datapath.
//
// Two views of the same result are provided:
//   * y             : combinational a & b for same-cycle consumers.
//   * y_q + flags   : a one-stage registered copy of a & b together with
//                     zero / all-ones / population-count status, all captured
//                     from the same sampled operands so they always agree
//                     with y_q.
//
// Ports
//   clk       in   1      rising-edge clock for the registered stage
//   rst_n     in   1      asynchronous active-low reset
//   a         in   WIDTH  operand A
//   b         in   WIDTH  operand B
//   en        in   1      capture enable for the registered stage
//   y         out  WIDTH  combinational a & b
//   y_q       out  WIDTH  registered a & b
//   valid_q   out  1      y_q holds a captured value
//   zero_q    out  1      y_q is all zeros
//   ones_q    out  1      y_q is all ones
//   popcnt_q  out  CNT_W  number of set bits in y_q
// ----------------------------------------------------------------------------
module and2_word #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             en,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output logic             valid_q,
   output logic             zero_q,
   output logic             ones_q,
   output logic [CNT_W-1:0] popcnt_q
);

   // Set-bit count of a word; unrolls into an adder tree at synthesis.
   function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [CNT_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt = cnt + CNT_W'(v[i]);
      end
      return cnt;
   endfunction

   logic [WIDTH-1:0] res_d;
   logic             zero_d;
   logic             ones_d;
   logic [CNT_W-1:0] popcnt_d;

   // Combinational stage: the result and every flag derive from one AND.
   always_comb begin
      res_d    = a & b;
      zero_d   = (res_d == '0);
      ones_d   = (res_d == '1);
      popcnt_d = popcount(res_d);
   end

   assign y = res_d;

   // Registered stage: zero_q resets high so the flags agree with y_q = 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q      <= '0;
         valid_q  <= 1'b0;
         zero_q   <= 1'b1;
         ones_q   <= 1'b0;
         popcnt_q <= '0;
      end else if (en) begin
         y_q      <= res_d;
         valid_q  <= 1'b1;
         zero_q   <= zero_d;
         ones_q   <= ones_d;
         popcnt_q <= popcnt_d;
      end
   end

endmodule

// File: tb/tb_and2_word.sv
module tb_and2_word;

   localparam int WIDTH = 32;
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] a, b;
   logic             en;
   logic [WIDTH-1:0] y, y_q;
   logic             valid_q, zero_q, ones_q;
   logic [CNT_W-1:0] popcnt_q;

   int checks   = 0;
   int failures = 0;

   and2_word #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .en(en),
      .y(y), .y_q(y_q), .valid_q(valid_q), .zero_q(zero_q),
      .ones_q(ones_q), .popcnt_q(popcnt_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        en;
      logic [31:0] exp_y;
      logic [31:0] exp_yq;
      logic        exp_valid;
      logic        exp_zero;
      logic        exp_ones;
      logic [5:0]  exp_pop;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic chk_regs(input string tag, input logic [31:0] eyq, input logic ev,
                           input logic ez, input logic eo, input logic [5:0] ep);
      chk({tag, ".y_q"},      y_q,                 eyq);
      chk({tag, ".valid_q"},  {31'b0, valid_q},    {31'b0, ev});
      chk({tag, ".zero_q"},   {31'b0, zero_q},     {31'b0, ez});
      chk({tag, ".ones_q"},   {31'b0, ones_q},     {31'b0, eo});
      chk({tag, ".popcnt_q"}, {26'b0, popcnt_q},   {26'b0, ep});
   endtask

   logic [31:0] m_yq;
   logic        m_v;
   logic [31:0] ra, rb;
   logic        ren;
   int          rnd_bad;

   initial begin
      vecs[0] = '{32'h12345678, 32'h12345678, 1'b1, 32'h12345678, 32'h12345678, 1'b1, 1'b0, 1'b0, 6'd13};
      vecs[1] = '{32'h00000000, 32'h12345678, 1'b1, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 6'd0};
      vecs[2] = '{32'h00000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 6'd0};
      vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 6'd32};
      vecs[4] = '{32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'h00F000F0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 6'd32};
      vecs[5] = '{32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'h00F000F0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 6'd32};
      vecs[6] = '{32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'h00F000F0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 6'd32};
      vecs[7] = '{32'hF0F0F0F0, 32'h0FF00FF0, 1'b1, 32'h00F000F0, 32'h00F000F0, 1'b1, 1'b0, 1'b0, 6'd8};
      vecs[8] = '{32'hAAAAAAAA, 32'hFFFF0000, 1'b1, 32'hAAAA0000, 32'hAAAA0000, 1'b1, 1'b0, 1'b0, 6'd8};
      vecs[9] = '{32'h80000001, 32'hFFFFFFFF, 1'b1, 32'h80000001, 32'h80000001, 1'b1, 1'b0, 1'b0, 6'd2};

      rst_n = 1'b0;
      a     = 32'h0;
      b     = 32'h0;
      en    = 1'b1;

      // Reset state, with edges passing while en=1 and y live during reset.
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_regs("reset", 32'h0, 1'b0, 1'b1, 1'b0, 6'd0);
      a = 32'hC3C3C3C3; b = 32'hFF00FF00;
      #1;
      chk("reset.y_live", y, 32'hC300C300);

      // Release with en=0: nothing captured, valid stays low.
      en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_regs("post_rst_en0", 32'h0, 1'b0, 1'b1, 1'b0, 6'd0);

      // Directed table.
      for (int i = 0; i < 10; i++) begin
         a  = vecs[i].a;
         b  = vecs[i].b;
         en = vecs[i].en;
         #1;
         chk($sformatf("vec%0d.y", i), y, vecs[i].exp_y);
         @(posedge clk);
         #1;
         chk_regs($sformatf("vec%0d", i), vecs[i].exp_yq, vecs[i].exp_valid,
                  vecs[i].exp_zero, vecs[i].exp_ones, vecs[i].exp_pop);
      end

      // Asynchronous reset between edges while y_q = all-ones.
      a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; en = 1'b1;
      @(posedge clk);
      #1;
      chk("arst_pre.y_q", y_q, 32'hFFFFFFFF);
      #2;
      rst_n = 1'b0;
      #1;
      chk_regs("arst_now", 32'h0, 1'b0, 1'b1, 1'b0, 6'd0);
      chk("arst_now.y", y, 32'hFFFFFFFF);
      // Pending capture during reset is discarded.
      @(posedge clk);
      #1;
      chk_regs("arst_hold", 32'h0, 1'b0, 1'b1, 1'b0, 6'd0);
      // First edge after release captures when en=1.
      @(negedge clk);
      rst_n = 1'b1;
      a = 32'h0000FFFF;
      @(posedge clk);
      #1;
      chk_regs("arst_first", 32'h0000FFFF, 1'b1, 1'b0, 1'b0, 6'd16);

      // Random run against a one-cycle reference model.
      m_yq = y_q;
      m_v  = valid_q;
      rnd_bad = 0;
      for (int c = 0; c < 1000; c++) begin
         ra  = $urandom;
         rb  = $urandom;
         if (c % 7 == 0) ra = 32'hFFFFFFFF;
         if (c % 11 == 0) rb = 32'h0;
         ren = 1'($urandom_range(0, 1));
         a = ra; b = rb; en = ren;
         #1;
         if (y !== (ra & rb)) rnd_bad++;
         if (ren) begin
            m_yq = ra & rb;
            m_v  = 1'b1;
         end
         @(posedge clk);
         #1;
         if (y_q !== m_yq || valid_q !== m_v ||
             zero_q !== (m_yq == 32'h0) || ones_q !== (m_yq == 32'hFFFFFFFF) ||
             popcnt_q !== 6'($countones(m_yq)) || (zero_q && ones_q)) begin
            if (rnd_bad < 5)
               $display("FAIL random cycle %0d actual y_q=%h pop=%0d z=%b o=%b v=%b expected y_q=%h pop=%0d v=%b",
                        c, y_q, popcnt_q, zero_q, ones_q, valid_q, m_yq, $countones(m_yq), m_v);
            rnd_bad++;
         end
      end
      chk("random.mismatch_count", rnd_bad, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule

// File: doc/and2_word.md
Name: and2_word

Overview:
- Parameterised bitwise two-input AND for data-path words, default 32 bits.
- Provides a combinational result for same-cycle use.
- Also provides a registered result stage with status flags (zero, all-ones, population count) for pipelined consumers.
- Sits in the ALU/logic-unit path as the AND primitive.

Parameters:
WIDTH, 32, data width of operands and result (>=1)
CNT_W, $clog2(WIDTH+1), width of the population-count output (6 for WIDTH=32)

Ports:
clk  input  1  rising-edge clock for the registered stage
rst_n  input  1  asynchronous active-low reset
a  input  WIDTH  operand A
b  input  WIDTH  operand B
en  input  1  capture enable for the registered stage
y  output  WIDTH  combinational result, a AND b
y_q  output  WIDTH  registered result
valid_q  output  1  registered result holds a captured value
zero_q  output  1  y_q is all zeros
ones_q  output  1  y_q is all ones
popcnt_q  output  CNT_W  number of set bits in y_q

Behaviour:
- Combinational path:
  - y[i] = a[i] & b[i] for every bit i.
  - Zero latency: y tracks a/b changes with no dependence on clk, rst_n or en.
  - No X-propagation masking; 0 & X = 0 per standard semantics.
- Registered stage, on each rising clk edge with en=1:
  - y_q <= a & b.
  - zero_q <= (a & b) == 0.
  - ones_q <= (a & b) == all-ones.
  - popcnt_q <= count of set bits in (a & b).
  - valid_q <= 1.
  - All of these are computed from the same sampled a/b, so the flags are always consistent with y_q in the same cycle.
- With en=0: all registered outputs hold their values; valid_q holds.
- Latency: one clock from the en=1 sample edge to the registered outputs.
- Reset:
  - rst_n low asserts immediately, independent of clk.
  - Reset values: y_q=0, valid_q=0, zero_q=1 (consistent with y_q=0), ones_q=0, popcnt_q=0.
  - Reset mid-operation discards any pending capture.
  - On the first rising edge after rst_n deasserts, a capture occurs if en=1.
  - y stays live during reset.
- Boundaries:
  - a=b=all-ones -> ones_q=1, popcnt_q=WIDTH.
  - Either operand zero -> zero_q=1, popcnt_q=0.
  - ones_q and zero_q are never both 1 (WIDTH>=1).
- Population count is a combinational adder tree over the result feeding the register; no multicycle paths.

Test Plan:
- a=0x12345678, b=0x12345678 -> y=0x12345678 immediately; after one en=1 edge: y_q=0x12345678, popcnt_q=13, zero_q=0, ones_q=0, valid_q=1.
- a=0x00000000, b=0x12345678 -> y=0x00000000; after an en=1 edge: zero_q=1, popcnt_q=0.
- a=0x00000000, b=0xFFFFFFFF -> y=0x00000000; then a=0xFFFFFFFF -> y=0xFFFFFFFF; after an en=1 edge: ones_q=1, popcnt_q=32.
- a=0xF0F0F0F0, b=0x0FF00FF0 with en=0 across 3 edges -> y=0x00F000F0 combinationally; y_q/flags unchanged. Then en=1 -> y_q=0x00F000F0, popcnt_q=8.
- Assert rst_n=0 between clock edges while y_q=0xFFFFFFFF -> outputs go to reset values at once (y_q=0, zero_q=1, valid_q=0). y still equals a&b during reset.
- Random a/b over 1000 cycles with random en -> y == a&b always; registered outputs match a one-cycle reference model.
